univ_shift_reg: RTL and testbench

//   Parametrised universal shift register: hold, shift-right, shift-left and parallel load.
//   One block covers SISO, SIPO, PISO and PIPO use, selected at run time by i_mode.
//   A shift counter frames serial words: it raises o_full and pulses o_word_strb once

---
 rtl/shreg_pkg.sv | 14 +
 rtl/shreg_bit_counter.sv | 40 ++++
 rtl/univ_shift_reg.sv | 73 +++++++
 tb/tb_univ_shift_reg.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/shreg_pkg.sv
// Shared definitions for the universal shift register and the serial front ends.
// Mode encodings are fixed because the front ends drive i_mode directly.
package shreg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'd0;
    localparam logic [1:0] MODE_SHR  = 2'd1;
    localparam logic [1:0] MODE_SHL  = 2'd2;
    localparam logic [1:0] MODE_LOAD = 2'd3;

    function automatic logic is_shift(input logic [1:0] mode);
        return (mode == MODE_SHR) || (mode == MODE_SHL);
    endfunction

endpackage

// File: rtl/shreg_bit_counter.sv
// Word-framing counter for the shift register: counts executed shifts up to WIDTH,
// flags a full word and strobes once on the shift that completes it.
module shreg_bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic inc,
    input  logic clr,
    output logic full,
    output logic word_strb
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] WORD_LEN = CW'(WIDTH);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] ZERO     = '0;

    // Held as shifts remaining in the word; zero is the saturated (full) state.
    logic [CW-1:0] remaining;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            remaining <= WORD_LEN;
            full      <= 1'b0;
            word_strb <= 1'b0;
        end else if (clr) begin
            remaining <= WORD_LEN;
            full      <= 1'b0;
            word_strb <= 1'b0;
        end else if (inc && (remaining != ZERO)) begin
            remaining <= remaining - ONE;
            full      <= (remaining == ONE);
            word_strb <= (remaining == ONE);
        end else begin
            word_strb <= 1'b0;
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register (hold / shift-right / shift-left / parallel load) with
// serial taps at both ends and a word-framing shift counter.
module univ_shift_reg
    import shreg_pkg::*;
#(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [1:0]       i_mode,
    input  logic             i_sin,
    input  logic [WIDTH-1:0] i_pdata,
    output logic [WIDTH-1:0] o_q,
    output logic             o_sout_r,
    output logic             o_sout_l,
    output logic             o_full,
    output logic             o_word_strb
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             cnt_inc;
    logic             cnt_clr;

    // Clear wins over everything, enable gates only the mode operation.
    always_comb begin
        q_next  = q_reg;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        if (i_clr) begin
            q_next  = RESET_VAL;
            cnt_clr = 1'b1;
        end else if (i_en) begin
            case (i_mode)
                MODE_SHR:  q_next = {i_sin, q_reg[WIDTH-1:1]};
                MODE_SHL:  q_next = {q_reg[WIDTH-2:0], i_sin};
                MODE_LOAD: begin
                    q_next  = i_pdata;
                    cnt_clr = 1'b1;
                end
                default:   q_next = q_reg;
            endcase
            cnt_inc = is_shift(i_mode);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            q_reg <= RESET_VAL;
        end else begin
            q_reg <= q_next;
        end
    end

    shreg_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .inc       (cnt_inc),
        .clr       (cnt_clr),
        .full      (o_full),
        .word_strb (o_word_strb)
    );

    assign o_q      = q_reg;
    assign o_sout_r = q_reg[0];
    assign o_sout_l = q_reg[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (WIDTH=8, RESET_VAL=0): stimulus pushes the
// expected register state, a monitor pops and compares after each edge or reset.
module tb_univ_shift_reg;
    import shreg_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_en = 1'b0;
    logic       i_clr = 1'b0;
    logic [1:0] i_mode = MODE_HOLD;
    logic       i_sin = 1'b0;
    logic [7:0] i_pdata = 8'h00;
    logic [7:0] o_q;
    logic       o_sout_r;
    logic       o_sout_l;
    logic       o_full;
    logic       o_word_strb;

    univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .i_clr       (i_clr),
        .i_mode      (i_mode),
        .i_sin       (i_sin),
        .i_pdata     (i_pdata),
        .o_q         (o_q),
        .o_sout_r    (o_sout_r),
        .o_sout_l    (o_sout_l),
        .o_full      (o_full),
        .o_word_strb (o_word_strb)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string      name;
        logic [7:0] q;
        logic       full;
        logic       strb;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   step   = 0;
    string tag   = "reset";

    // reference state
    logic [7:0] mq    = 8'h00;
    int         mcnt  = 0;
    logic       mstrb = 1'b0;

    task automatic push_exp(input logic [7:0] q, input logic full, input logic strb);
        exp_t e;
        e.name = $sformatf("%s_%0d", tag, step);
        e.q    = q;
        e.full = full;
        e.strb = strb;
        sb.push_back(e);
        step++;
    endtask

    task automatic model_step(input logic clr, input logic en, input logic [1:0] mode,
                              input logic sin, input logic [7:0] pd);
        mstrb = 1'b0;
        if (clr) begin
            mq = 8'h00; mcnt = 0;
        end else if (en) begin
            if (mode == MODE_LOAD) begin
                mq = pd; mcnt = 0;
            end else if (mode == MODE_SHR || mode == MODE_SHL) begin
                mq = (mode == MODE_SHR) ? {sin, mq[7:1]} : {mq[6:0], sin};
                if (mcnt < 8) begin
                    mcnt++;
                    if (mcnt == 8) mstrb = 1'b1;
                end
            end
        end
    endtask

    task automatic cyc(input logic clr, input logic en, input logic [1:0] mode,
                       input logic sin, input logic [7:0] pd);
        @(negedge i_clk);
        i_clr = clr; i_en = en; i_mode = mode; i_sin = sin; i_pdata = pd;
        model_step(clr, en, mode, sin, pd);
        push_exp(mq, (mcnt == 8), mstrb);
    endtask

    // hold cycle whose expected state is given by hand rather than by the model
    task automatic hand_check(input string t, input logic [7:0] q, input logic full);
        @(negedge i_clk);
        i_clr = 1'b0; i_en = 1'b1; i_mode = MODE_HOLD; i_sin = 1'b0;
        model_step(1'b0, 1'b1, MODE_HOLD, 1'b0, 8'h00);
        tag = t;
        push_exp(q, full, 1'b0);
    endtask

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge i_clk or negedge i_rst);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_chk++;
                if (o_q === e.q && o_full === e.full && o_word_strb === e.strb &&
                    o_sout_r === e.q[0] && o_sout_l === e.q[7]) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got q=%h full=%b strb=%b sout_r=%b sout_l=%b, expected q=%h full=%b strb=%b sout_r=%b sout_l=%b",
                             e.name, o_q, o_full, o_word_strb, o_sout_r, o_sout_l,
                             e.q, e.full, e.strb, e.q[0], e.q[7]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    logic [7:0] shl_bits;

    initial begin
        // reset held across an edge
        @(negedge i_clk);
        tag = "reset";
        push_exp(8'h00, 1'b0, 1'b0);
        @(negedge i_clk);
        i_rst = 1'b1;

        // 1: async reset mid-shift
        tag = "t1"; step = 0;
        cyc(0, 1, MODE_LOAD, 0, 8'hFF);
        repeat (3) cyc(0, 1, MODE_SHR, 0, 8'h00);
        @(negedge i_clk);
        i_en = 1'b0; i_mode = MODE_HOLD;
        #2;
        mq = 8'h00; mcnt = 0; mstrb = 1'b0;
        tag = "t1_async_rst";
        push_exp(8'h00, 1'b0, 1'b0);
        i_rst = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;

        // 2: load A5 and shift it out to the right
        tag = "t2"; step = 0;
        cyc(0, 1, MODE_LOAD, 0, 8'hA5);
        repeat (8) cyc(0, 1, MODE_SHR, 0, 8'h00);
        hand_check("t2_final", 8'h00, 1'b1);

        // 3: clear then shift D2 in from the left side
        tag = "t3"; step = 0;
        cyc(1, 0, MODE_HOLD, 0, 8'h00);
        shl_bits = 8'b1101_0010;
        for (int i = 7; i >= 0; i--) cyc(0, 1, MODE_SHL, shl_bits[i], 8'h00);
        hand_check("t3_final", 8'hD2, 1'b1);

        // 4: test 2 with disabled cycles between shifts; modes while disabled are ignored
        tag = "t4"; step = 0;
        cyc(0, 1, MODE_LOAD, 0, 8'hA5);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, MODE_SHR, 0, 8'h00);
            cyc(0, 0, MODE_SHL, 1, 8'h77);
            cyc(0, 0, MODE_LOAD, 1, 8'h77);
        end
        hand_check("t4_final", 8'h00, 1'b1);

        // 5: clear beats load, and clear works with enable low
        tag = "t5"; step = 0;
        cyc(0, 1, MODE_LOAD, 0, 8'h99);
        cyc(1, 1, MODE_LOAD, 0, 8'h3C);
        cyc(0, 1, MODE_LOAD, 0, 8'h3C);
        repeat (3) cyc(0, 1, MODE_SHR, 1, 8'h00);
        cyc(1, 0, MODE_SHR, 1, 8'h00);
        repeat (7) cyc(0, 1, MODE_SHL, 1, 8'h00);
        cyc(0, 1, MODE_SHR, 0, 8'h00);

        // 6: saturation past the word boundary, then reload
        tag = "t6"; step = 0;
        cyc(1, 1, MODE_HOLD, 0, 8'h00);
        for (int i = 0; i < 10; i++) cyc(0, 1, (i % 3 == 2) ? MODE_SHL : MODE_SHR, i[0], 8'h00);
        cyc(0, 1, MODE_LOAD, 0, 8'h01);
        hand_check("t6_final", 8'h01, 1'b0);

        repeat (3) @(posedge i_clk);
        #2;
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
